// File: rtl/mul_div_unit_if.sv
// Operation/register port bundle for the iterative multiply/divide unit.
// The master side issues operations and HI/LO writes, the slave side is the unit.
interface mul_div_unit_if;
  logic        start;
  logic [1:0]  MD_Control;
  logic [31:0] A_input;
  logic [31:0] B_input;
  logic        HI_write;
  logic        LO_write;
  logic [31:0] WriteData;
  logic        busy;
  logic        done;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output start, MD_Control, A_input, B_input, HI_write, LO_write, WriteData,
    input  busy, done, HI, LO
  );

  modport slave (
    input  start, MD_Control, A_input, B_input, HI_write, LO_write, WriteData,
    output busy, done, HI, LO
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO pair.
// Operands are converted to magnitudes at start, 32 one-bit iterations run,
// and a single fix-up cycle applies the signs and writes HI/LO.
module mul_div_unit (
  input logic           clk,
  input logic           reset,
  mul_div_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state, state_next;
  logic        busy;
  logic        start_ok;
  logic        op_div;
  logic [31:0] a_raw;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        neg_q;
  logic        neg_r;
  logic [4:0]  count;
  logic [63:0] acc;
  logic [31:0] rem;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        done_q;

  logic        sign_in;
  logic [31:0] a_abs_in;
  logic [31:0] b_abs_in;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [32:0] div_diff;
  logic [63:0] prod_fixed;
  logic [31:0] quo_fixed;
  logic [31:0] rem_fixed;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; busy covers both CALC and FIX
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    start_ok   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          start_ok   = 1'b1;
          state_next = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (count == 5'd31) state_next = FIX;
      end
      FIX: begin
        busy       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand magnitudes, one iteration step of each algorithm, and sign fix-up
  always_comb begin
    sign_in    = bus.MD_Control[0];
    a_abs_in   = (sign_in && bus.A_input[31]) ? (32'd0 - bus.A_input) : bus.A_input;
    b_abs_in   = (sign_in && bus.B_input[31]) ? (32'd0 - bus.B_input) : bus.B_input;
    mul_sum    = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, a_mag} : 33'd0);
    div_shift  = {rem, acc[31]};
    div_diff   = div_shift - {1'b0, b_mag};
    prod_fixed = neg_q ? (64'd0 - acc) : acc;
    quo_fixed  = neg_q ? (32'd0 - acc[31:0]) : acc[31:0];
    rem_fixed  = neg_r ? (32'd0 - rem) : rem;
  end

  // Datapath: latch magnitudes/sign flags at start, then iterate one bit per cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      op_div <= 1'b0;
      a_raw  <= 32'd0;
      a_mag  <= 32'd0;
      b_mag  <= 32'd0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      count  <= 5'd0;
      acc    <= 64'd0;
      rem    <= 32'd0;
    end else if (start_ok) begin
      op_div <= bus.MD_Control[1];
      a_raw  <= bus.A_input;
      a_mag  <= a_abs_in;
      b_mag  <= b_abs_in;
      neg_q  <= sign_in & (bus.A_input[31] ^ bus.B_input[31]);
      neg_r  <= sign_in & bus.A_input[31];
      count  <= 5'd0;
      rem    <= 32'd0;
      acc    <= bus.MD_Control[1] ? {32'd0, a_abs_in} : {32'd0, b_abs_in};
    end else if (state == CALC) begin
      count <= count + 5'd1;
      if (op_div) begin
        if (!div_diff[32]) begin
          rem        <= div_diff[31:0];
          acc[31:0]  <= {acc[30:0], 1'b1};
        end else begin
          rem        <= div_shift[31:0];
          acc[31:0]  <= {acc[30:0], 1'b0};
        end
      end else begin
        acc <= {mul_sum, acc[31:1]};
      end
    end
  end

  // HI/LO: MTHI/MTLO only while idle, result lands in FIX; divide-by-zero special case
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else if (state == FIX) begin
      if (!op_div) begin
        hi_q <= prod_fixed[63:32];
        lo_q <= prod_fixed[31:0];
      end else if (b_mag == 32'd0) begin
        hi_q <= a_raw;
        lo_q <= 32'hFFFF_FFFF;
      end else begin
        hi_q <= rem_fixed;
        lo_q <= quo_fixed;
      end
    end else if (state == IDLE) begin
      if (bus.HI_write) hi_q <= bus.WriteData;
      if (bus.LO_write) lo_q <= bus.WriteData;
    end
  end

  // One-cycle completion pulse coinciding with the first cycle of the new HI/LO
  always_ff @(posedge clk) begin
    if (reset) done_q <= 1'b0;
    else       done_q <= (state == FIX);
  end

  assign bus.busy = busy;
  assign bus.done = done_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed cases plus randomized operations
// checked against a plain-arithmetic reference model.
module tb_mul_div_unit;

  logic clk;
  logic reset;
  mul_div_unit_if bus();

  mul_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          done_cyc;
  } exp_t;

  exp_t        sb[$];
  int          tests  = 0;
  int          failed = 0;
  int          cyc    = 0;
  logic [31:0] last_hi = 32'd0;
  logic [31:0] last_lo = 32'd0;

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used for latency checks
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: architectural results from plain integer arithmetic
  function automatic void refModel(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b,
                                   output logic [31:0] hi, output logic [31:0] lo);
    logic [63:0] p;
    longint      sp, sq, sr;
    case (op)
      2'd0: begin
        p  = {32'd0, a} * {32'd0, b};
        hi = p[63:32];
        lo = p[31:0];
      end
      2'd1: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        hi = sp[63:32];
        lo = sp[31:0];
      end
      default: begin
        if (b == 32'd0) begin
          hi = a;
          lo = 32'hFFFF_FFFF;
        end else if (op == 2'd2) begin
          lo = a / b;
          hi = a % b;
        end else begin
          sq = longint'($signed(a)) / longint'($signed(b));
          sr = longint'($signed(a)) % longint'($signed(b));
          lo = sq[31:0];
          hi = sr[31:0];
        end
      end
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Drive a start for one cycle from the current negedge; optionally record the expected result
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b, input bit track);
    exp_t e;
    bus.start      = 1'b1;
    bus.MD_Control = op;
    bus.A_input    = a;
    bus.B_input    = b;
    if (track) begin
      refModel(op, a, b, e.hi, e.lo);
      e.done_cyc = cyc + 34;
      sb.push_back(e);
      last_hi = e.hi;
      last_lo = e.lo;
    end
    @(negedge clk);
    bus.start      = 1'b0;
    bus.MD_Control = 2'($urandom);
    bus.A_input    = $urandom;
    bus.B_input    = $urandom;
  endtask

  // Wait (bounded) for done, counting busy cycles on the way
  task automatic waitDone(output int busy_cycles);
    bit got;
    busy_cycles = 0;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.done) begin
        got = 1'b1;
        break;
      end
      if (bus.busy) busy_cycles++;
      @(negedge clk);
    end
    if (!got) begin
      tests++;
      failed++;
      $display("[TB] FAIL done_timeout: no done within 100 cycles (cycle %0d)", cyc);
    end
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      4:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every done pulse pops one expectation and checks value and latency
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.done) begin
        if (sb.size() == 0) begin
          tests++;
          failed++;
          $display("[TB] FAIL unexpected_done: done=1 with no pending operation (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          checkOutput("result_hi", bus.HI, e.hi);
          checkOutput("result_lo", bus.LO, e.lo);
          checkOutput("done_cycle", cyc, e.done_cyc);
          checkOutput("busy_at_done", bus.busy, 0);
        end
      end
    end
  end

  // Directed and randomized stimulus
  initial begin
    int          bc;
    logic [31:0] hold_lo;
    logic [1:0]  op;
    logic [31:0] a, b;

    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.MD_Control = 2'd0;
    bus.A_input   = 32'd0;
    bus.B_input   = 32'd0;
    bus.HI_write  = 1'b0;
    bus.LO_write  = 1'b0;
    bus.WriteData = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checkOutput("reset_busy", bus.busy, 0);
    checkOutput("reset_done", bus.done, 0);
    checkOutput("reset_hi", bus.HI, 0);
    checkOutput("reset_lo", bus.LO, 0);

    applyStimulus(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    waitDone(bc);
    checkOutput("multu_busy_cycles", bc, 33);

    // Back-to-back starts presented in the done cycle
    applyStimulus(2'd1, 32'hFFFF_FFFD, 32'h0000_0007, 1);
    waitDone(bc);
    applyStimulus(2'd1, 32'h8000_0000, 32'h8000_0000, 1);
    waitDone(bc);
    applyStimulus(2'd3, 32'hFFFF_FFF9, 32'h0000_0002, 1);
    waitDone(bc);
    applyStimulus(2'd2, 32'd7, 32'd2, 1);
    waitDone(bc);
    applyStimulus(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    waitDone(bc);
    applyStimulus(2'd2, 32'd100, 32'd0, 1);
    waitDone(bc);
    checkOutput("div0_busy_cycles", bc, 33);

    // Start and MTLO while busy are both ignored
    @(negedge clk);
    hold_lo = last_lo;
    applyStimulus(2'd0, 32'd5, 32'd6, 1);
    repeat (9) @(negedge clk);
    bus.start      = 1'b1;
    bus.MD_Control = 2'd0;
    bus.A_input    = 32'd9;
    bus.B_input    = 32'd9;
    bus.LO_write   = 1'b1;
    bus.WriteData  = 32'h1234;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.LO_write = 1'b0;
    checkOutput("mtlo_busy_ignored", bus.LO, hold_lo);
    waitDone(bc);

    // MTHI while idle
    @(negedge clk);
    bus.HI_write  = 1'b1;
    bus.WriteData = 32'hABCD;
    @(negedge clk);
    bus.HI_write = 1'b0;
    checkOutput("mthi_idle_hi", bus.HI, 32'hABCD);
    checkOutput("mthi_idle_lo", bus.LO, 32'd30);

    // MTLO coinciding with start lands now and is overwritten by the result
    bus.LO_write  = 1'b1;
    bus.WriteData = 32'h5555;
    applyStimulus(2'd2, 32'd1000, 32'd7, 1);
    bus.LO_write = 1'b0;
    checkOutput("mtlo_with_start", bus.LO, 32'h5555);
    waitDone(bc);

    // Reset in the middle of a DIV loses the operation
    @(negedge clk);
    applyStimulus(2'd3, 32'hFFFF_F000, 32'd13, 0);
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midreset_busy", bus.busy, 0);
    checkOutput("midreset_done", bus.done, 0);
    checkOutput("midreset_hi", bus.HI, 0);
    checkOutput("midreset_lo", bus.LO, 0);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    applyStimulus(2'd0, 32'd2, 32'd3, 1);
    waitDone(bc);

    // Randomized operations, with and without idle gaps
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = pickOperand();
      b  = pickOperand();
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      applyStimulus(op, a, b, 1);
      waitDone(bc);
      checkOutput("rand_busy_cycles", bc, 33);
    end

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
